// File: rtl/tmds_decode_channel.sv
// TMDS receive channel: bit-offset search on control-token runs, then per-character decode.
// Optional macro TMDS_ERR_COUNT_EN builds the saturating lock-loss counter behind err_count.
module tmds_decode_channel #(
   parameter int unsigned CTRL_RUN       = 16,
   parameter int unsigned SEARCH_TIMEOUT = 2048,
   parameter int unsigned LOSS_TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] tmds_in,
   output logic [7:0] data_out,
   output logic [1:0] ctrl_out,
   output logic       de,
   output logic       locked,
   output logic [3:0] offset,
   output logic [7:0] err_count
);
   localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
   localparam int unsigned TMR_W  = $clog2(SEARCH_TIMEOUT);
   localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [9:0]        r_prev;
   logic [3:0]        r_offset, w_offset_nxt;
   logic [RUN_W-1:0]  r_run, w_run_nxt;
   logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
   logic [LOSS_W-1:0] r_loss, w_loss_nxt;
   logic [7:0]        r_data;
   logic [1:0]        r_ctrl;
   logic              r_de;

   logic [19:0]       w_window;
   logic [4:0]        w_idx;
   logic [9:0]        w_word;
   logic              w_tok;
   logic [1:0]        w_ctrl;
   logic [7:0]        w_d;
   logic [7:0]        w_dec;

   // The aligned word is a combinational select feeding the output registers,
   // so offset 0 (the previous word) reaches the outputs two clocks after entry.
   assign w_window = {tmds_in, r_prev};
   assign w_idx    = {1'b0, r_offset};
   assign w_word   = w_window[w_idx +: 10];

   always_comb begin
      w_tok  = 1'b1;
      w_ctrl = 2'b00;
      case (w_word)
         10'b1101010100: w_ctrl = 2'b00;
         10'b0010101011: w_ctrl = 2'b01;
         10'b0101010100: w_ctrl = 2'b10;
         10'b1010101011: w_ctrl = 2'b11;
         default:        w_tok  = 1'b0;
      endcase
   end

   always_comb begin
      w_d      = w_word[9] ? ~w_word[7:0] : w_word[7:0];
      w_dec    = '0;
      w_dec[0] = w_d[0];
      for (int unsigned i = 1; i < 8; i++)
         w_dec[i] = w_word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_offset_nxt = r_offset;
      w_run_nxt    = r_run;
      w_tmr_nxt    = r_tmr;
      w_loss_nxt   = r_loss;
      case (r_state)
         ST_SEARCH: begin
            if (w_tok && (r_run == RUN_W'(CTRL_RUN - 1))) begin
               w_state_nxt = ST_LOCKED;
               w_run_nxt   = '0;
               w_tmr_nxt   = '0;
               w_loss_nxt  = '0;
            end else if (r_tmr == TMR_W'(SEARCH_TIMEOUT - 1)) begin
               w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
               w_run_nxt    = '0;
               w_tmr_nxt    = '0;
            end else begin
               w_run_nxt = w_tok ? r_run + 1'b1 : '0;
               w_tmr_nxt = r_tmr + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_tok) begin
               w_loss_nxt = '0;
            end else if (r_loss == LOSS_W'(LOSS_TIMEOUT - 1)) begin
               w_state_nxt = ST_SEARCH;
               w_run_nxt   = '0;
               w_tmr_nxt   = '0;
               w_loss_nxt  = '0;
            end else begin
               w_loss_nxt = r_loss + 1'b1;
            end
         end
         default: w_state_nxt = ST_SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_SEARCH;
         r_prev   <= '0;
         r_offset <= '0;
         r_run    <= '0;
         r_tmr    <= '0;
         r_loss   <= '0;
         r_data   <= '0;
         r_ctrl   <= '0;
         r_de     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_prev   <= tmds_in;
         r_offset <= w_offset_nxt;
         r_run    <= w_run_nxt;
         r_tmr    <= w_tmr_nxt;
         r_loss   <= w_loss_nxt;
         if (r_state == ST_LOCKED) begin
            r_de   <= ~w_tok;
            r_data <= w_tok ? 8'h00 : w_dec;
            r_ctrl <= w_tok ? w_ctrl : 2'b00;
         end else begin
            r_de   <= 1'b0;
            r_data <= '0;
            r_ctrl <= '0;
         end
      end
   end

`ifdef TMDS_ERR_COUNT_EN
   logic       w_lose;
   logic [7:0] r_err;

   assign w_lose = (r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH);

   always_ff @(posedge clk) begin
      if (reset)
         r_err <= '0;
      else if (w_lose && (r_err != 8'hFF))
         r_err <= r_err + 8'd1;
   end

   assign err_count = r_err;
`else
   assign err_count = 8'd0;
`endif

   assign data_out = r_data;
   assign ctrl_out = r_ctrl;
   assign de       = r_de;
   assign locked   = (r_state == ST_LOCKED);
   assign offset   = r_offset;

endmodule

// File: tb/tb_tmds_decode_channel.sv
// Randomised bench for tmds_decode_channel against a cycle-level behavioural model.
// Define TMDS_ERR_COUNT_EN for both files to exercise the lock-loss counter.
module tb_tmds_decode_channel;
   localparam int CTRL_RUN       = 16;
   localparam int SEARCH_TIMEOUT = 2048;
   localparam int LOSS_TIMEOUT   = 4096;
   localparam logic [9:0] TOK0   = 10'b1101010100;
   localparam logic [9:0] DZERO  = 10'b0100000000;
`ifdef TMDS_ERR_COUNT_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic [9:0] tmds_in = '0;
   logic [9:0] tmds_s  = '0;
   logic [7:0] data_out, data_s;
   logic [1:0] ctrl_out, ctrl_s;
   logic       de, de_s, locked, locked_s;
   logic [3:0] offset, offset_s;
   logic [7:0] err_count, err_s;

   always #5 clk = ~clk;

   tmds_decode_channel #(
      .CTRL_RUN(CTRL_RUN), .SEARCH_TIMEOUT(SEARCH_TIMEOUT), .LOSS_TIMEOUT(LOSS_TIMEOUT)
   ) u_dut (
      .clk(clk), .reset(reset), .tmds_in(tmds_in), .data_out(data_out), .ctrl_out(ctrl_out),
      .de(de), .locked(locked), .offset(offset), .err_count(err_count)
   );

   // Tiny timeouts so hundreds of lock/loss cycles fit in a short run.
   tmds_decode_channel #(
      .CTRL_RUN(2), .SEARCH_TIMEOUT(16), .LOSS_TIMEOUT(4)
   ) u_small (
      .clk(clk), .reset(reset), .tmds_in(tmds_s), .data_out(data_s), .ctrl_out(ctrl_s),
      .de(de_s), .locked(locked_s), .offset(offset_s), .err_count(err_s)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [9:0] TOKS [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

   logic [9:0] m_prev = '0;
   int         m_off  = 0, m_run = 0, m_tmr = 0, m_loss = 0, m_err = 0;
   bit         m_lock = 1'b0;
   bit         e_de   = 1'b0;
   logic [7:0] e_data = '0;
   logic [1:0] e_ctrl = '0;

   logic [9:0] chars [$];
   logic [7:0] ramp  [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int tok_code(input logic [9:0] w);
      for (int i = 0; i < 4; i++)
         if (w == TOKS[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] ref_decode(input logic [9:0] w);
      logic [7:0] d;
      d = w[9] ? ~w[7:0] : w[7:0];
      return (d ^ (d << 1)) ^ (w[8] ? 8'h00 : 8'hFE);
   endfunction

   // Transition-minimising stage of the channel encoder plus an arbitrary inversion flag.
   function automatic logic [9:0] encode(input logic [7:0] b, input logic inv);
      logic [7:0] q;
      int         ones;
      bit         xn;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      xn   = (ones > 4) || (ones == 4 && b[0] == 1'b0);
      q[0] = b[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
      return {inv, ~xn, inv ? ~q : q};
   endfunction

   function automatic logic [9:0] rot7(input int k);
      logic [9:0] c, p;
      c = chars[k % chars.size()];
      p = chars[(k + chars.size() - 1) % chars.size()];
      return {c[2:0], p[9:3]};
   endfunction

   task automatic model_step(input logic [9:0] x, input logic rst);
      logic [19:0] win;
      logic [9:0]  w;
      int          c;
      if (rst) begin
         m_prev = '0; m_off = 0; m_lock = 1'b0; m_run = 0; m_tmr = 0; m_loss = 0; m_err = 0;
         e_de = 1'b0; e_data = '0; e_ctrl = '0;
      end else begin
         win    = {x, m_prev};
         w      = 10'(win >> m_off);
         c      = tok_code(w);
         e_de   = m_lock && (c < 0);
         e_data = e_de ? ref_decode(w) : 8'h00;
         e_ctrl = (m_lock && c >= 0) ? 2'(c) : 2'b00;
         if (!m_lock) begin
            if (c >= 0 && m_run + 1 == CTRL_RUN) begin
               m_lock = 1'b1; m_run = 0; m_tmr = 0; m_loss = 0;
            end else if (m_tmr + 1 == SEARCH_TIMEOUT) begin
               m_off = (m_off + 1) % 10; m_run = 0; m_tmr = 0;
            end else begin
               m_run = (c >= 0) ? m_run + 1 : 0;
               m_tmr++;
            end
         end else begin
            if (c >= 0) m_loss = 0;
            else if (m_loss + 1 == LOSS_TIMEOUT) begin
               m_lock = 1'b0; m_run = 0; m_tmr = 0; m_loss = 0;
               if (ERR_EN != 0 && m_err < 255) m_err++;
            end else m_loss++;
         end
         m_prev = x;
      end
   endtask

   task automatic tick(input logic [9:0] x);
      logic [23:0] obs, exp;
      tmds_in = x;
      @(posedge clk);
      model_step(x, reset);
      #1;
      exp = {m_lock, 4'(m_off), e_de, e_data, e_ctrl, 8'(m_err)};
      obs = {locked, offset, de, e_de ? data_out : 8'h00, e_de ? 2'b00 : ctrl_out, err_count};
      check_val("cycle", 32'(obs), 32'(exp));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(10'($urandom));
      reset = 1'b0;
   endtask

   function automatic logic [9:0] rand_data();
      logic [9:0] w;
      do w = encode(8'($urandom), 1'($urandom)); while (tok_code(w) >= 0);
      return w;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         k;
      int         r;
      logic [9:0] w;

      for (int i = 0; i < 138; i++) chars.push_back(TOK0);
      for (int i = 0; i < 720; i++) begin
         ramp.push_back(8'(i % 256));
         chars.push_back(encode(8'(i % 256), 1'($urandom)));
      end

      // Aligned encoder stream: lock timing and two-clock data latency.
      do_reset();
      check_val("rst_err_small", 32'(err_s), 32'd0);
      for (int i = 1; i <= chars.size() + 2; i++) begin
         tick(i <= chars.size() ? chars[i-1] : TOK0);
         if (i == 16) check_val("lock_pre", 32'(locked), 32'd0);
         if (i == 17) check_val("lock_at", 32'(locked), 32'd1);
         if (i >= 140 && i <= 859) begin
            check_val("ramp_de", 32'(de), 32'd1);
            check_val("ramp_data", 32'(data_out), 32'(ramp[i-140]));
         end
      end

      // Stream rotated by 7 bits: offset walks 0..7, then locks.
      do_reset();
      k = 0;
      for (int t = 1; t <= 7 * SEARCH_TIMEOUT; t++) begin
         tick(rot7(k)); k++;
         if (t % SEARCH_TIMEOUT == SEARCH_TIMEOUT - 1)
            check_val("slip_pre", 32'(offset), 32'(t / SEARCH_TIMEOUT));
         if (t % SEARCH_TIMEOUT == 0)
            check_val("slip", 32'(offset), 32'(t / SEARCH_TIMEOUT));
      end
      for (int t = 0; t < SEARCH_TIMEOUT && !locked; t++) begin
         tick(rot7(k)); k++;
      end
      check_val("rot_locked", 32'(locked), 32'd1);
      check_val("rot_offset", 32'(offset), 32'd7);
      for (int t = 0; t < 900; t++) begin
         tick(rot7(k)); k++;
      end

      // One-clock reset while locked at offset 7.
      reset = 1'b1;
      tick(10'($urandom));
      reset = 1'b0;
      check_val("rst_locked", 32'(locked), 32'd0);
      check_val("rst_offset", 32'(offset), 32'd0);
      check_val("rst_de", 32'(de), 32'd0);
      check_val("rst_data", 32'(data_out), 32'd0);
      check_val("rst_err", 32'(err_count), 32'd0);

      // Directed aligned words, then a random token/data mix while locked.
      for (int t = 0; t < 20; t++) tick(TOK0);
      check_val("relock", 32'(locked), 32'd1);
      tick(10'b1010101011); tick(TOK0);
      check_val("tok11_ctrl", 32'(ctrl_out), 32'd3);
      check_val("tok11_de", 32'(de), 32'd0);
      tick(10'b0100000000); tick(TOK0);
      check_val("d00_data", 32'(data_out), 32'h00);
      check_val("d00_de", 32'(de), 32'd1);
      tick(10'b1011111111); tick(TOK0);
      check_val("dfe_data", 32'(data_out), 32'hFE);
      for (int t = 0; t < 2000; t++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3)      w = TOKS[$urandom_range(0, 3)];
         else if (r < 7) w = rand_data();
         else            w = 10'($urandom);
         tick(w);
      end
      tick(TOK0);

      // Token starvation while locked.
      for (int t = 1; t <= LOSS_TIMEOUT + 2; t++) begin
         tick(rand_data());
         if (t == LOSS_TIMEOUT)     check_val("loss_pre", 32'(locked), 32'd1);
         if (t == LOSS_TIMEOUT + 1) begin
            check_val("loss_at", 32'(locked), 32'd0);
            check_val("loss_offset", 32'(offset), 32'd0);
         end
         if (t == LOSS_TIMEOUT + 2) check_val("loss_de", 32'(de), 32'd0);
      end

      // Two further lock losses, then saturation on the small instance.
      for (int n = 0; n < 2; n++) begin
         for (int t = 0; t < 20; t++) tick(TOK0);
         for (int t = 0; t < LOSS_TIMEOUT + 2; t++) tick(DZERO);
      end
      check_val("err_three", 32'(err_count), 32'(ERR_EN * 3));
      for (int p = 0; p < 310; p++) begin
         for (int j = 0; j < 6; j++) begin
            tmds_s = (j < 2) ? TOK0 : DZERO;
            tick(DZERO);
         end
      end
      check_val("err_sat", 32'(err_s), 32'(ERR_EN * 255));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
